// File: rtl/cv32e40p_tmr_pkg.sv
// ----------------------------------------------------------------------------
// cv32e40p_tmr_pkg
// Shared types and constants for the TMR fault manager.
//   tmr_state_e : fault-manager FSM state, also exported on state_o
//   REPL_A/B/C  : one-hot replica selectors, bit order {c,b,a}
//   REPL_NUM    : number of replicas
//   popcnt3()   : number of set bits in a 3-bit replica vector
// ----------------------------------------------------------------------------
package cv32e40p_tmr_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        RESYNC   = 2'd1,
        DEGRADED = 2'd2,
        FATAL    = 2'd3
    } tmr_state_e;

    localparam int          REPL_NUM = 3;
    localparam logic [2:0]  REPL_A   = 3'b001;
    localparam logic [2:0]  REPL_B   = 3'b010;
    localparam logic [2:0]  REPL_C   = 3'b100;

    function automatic logic [1:0] popcnt3(input logic [2:0] v);
        return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    endfunction

endpackage

// File: rtl/cv32e40p_tmr_err_counter.sv
// ----------------------------------------------------------------------------
// cv32e40p_tmr_err_counter
// Leaky, saturating per-replica error counter.
//   clk       in   core clock
//   rst_n     in   asynchronous active-low reset
//   inc_i     in   +1 request (saturates at all-ones)
//   leak_i    in   -1 request (floors at zero)
//   freeze_i  in   hold the count (replica isolated)
//   cnt_o     out  current count
// ----------------------------------------------------------------------------
module cv32e40p_tmr_err_counter
    import cv32e40p_tmr_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             leak_i,
    input  logic             freeze_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Increment and leak together cancel out.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (!freeze_i) begin
            if (inc_i && !leak_i && (r_cnt != CNT_MAX)) begin
                w_cnt_nxt = r_cnt + 1'b1;
            end else if (leak_i && !inc_i && (r_cnt != '0)) begin
                w_cnt_nxt = r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/cv32e40p_tmr_fault_manager.sv
// ----------------------------------------------------------------------------
// cv32e40p_tmr_fault_manager
// Consumes the TMR voter mismatch flags, keeps leaky per-replica error counts,
// requests replica resync, isolates persistently failing replicas and raises a
// sticky fatal flag once majority voting cannot be trusted.
//   clk               in   core clock
//   rst_n             in   asynchronous active-low reset
//   valid_i           in   voter comparison valid
//   err_a/b/c_i       in   voter per-replica mismatch flags
//   resync_ack_i      in   resync done (meaningful while resync_req_o=1)
//   resync_req_o      out  resync request
//   resync_sel_o      out  one-hot replica to resync {c,b,a}
//   replica_disable_o out  sticky isolation {c,b,a}
//   fatal_o           out  sticky unrecoverable fault
//   state_o           out  FSM state
//   err_cnt_o         out  error counters {c,b,a}
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | all replicas healthy, no resync outstanding
// RESYNC   | request outstanding for replica resync_sel_o
// DEGRADED | one replica isolated, running on the other two
// FATAL    | voting untrustworthy, absorbing until reset
// ----------------------------------------------------------------------------
module cv32e40p_tmr_fault_manager
    import cv32e40p_tmr_pkg::*;
#(
    parameter int CNT_W          = 8,
    parameter int THRESH         = 4,
    parameter int WINDOW         = 1024,
    parameter int RESYNC_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_i,
    input  logic                err_a_i,
    input  logic                err_b_i,
    input  logic                err_c_i,
    input  logic                resync_ack_i,
    output logic                resync_req_o,
    output logic [2:0]          resync_sel_o,
    output logic [2:0]          replica_disable_o,
    output logic                fatal_o,
    output logic [1:0]          state_o,
    output logic [3*CNT_W-1:0]  err_cnt_o
);

    localparam int WIN_W = $clog2(WINDOW);
    localparam int TMO_W = $clog2(RESYNC_TIMEOUT + 1);

    tmr_state_e       r_state;
    tmr_state_e       w_state_nxt;
    logic             r_req;
    logic [2:0]       r_sel;
    logic [2:0]       r_disable;
    logic             r_fatal;
    logic [TMO_W-1:0] r_tmo;
    logic [WIN_W-1:0] r_win;

    logic             w_req_nxt;
    logic [2:0]       w_sel_nxt;
    logic [2:0]       w_disable_nxt;
    logic             w_fatal_nxt;
    logic [TMO_W-1:0] w_tmo_nxt;

    logic [2:0]       w_err;
    logic [1:0]       w_nerr;
    logic             w_single;
    logic             w_multi;
    logic             w_sel_hit;
    logic             w_other_hit;
    logic             w_leak;
    logic             w_tmo_hit;
    logic             w_thresh_hit;
    logic [CNT_W-1:0] w_hit_cnt;
    logic [CNT_W-1:0] w_post_cnt;
    logic [CNT_W-1:0] w_cnt [REPL_NUM];

    // Classification ignores isolated replicas entirely.
    assign w_err       = valid_i ? ({err_c_i, err_b_i, err_a_i} & ~r_disable) : 3'b000;
    assign w_nerr      = popcnt3(w_err);
    assign w_single    = (w_nerr == 2'd1);
    assign w_multi     = (w_nerr >= 2'd2);
    assign w_sel_hit   = w_single && (w_err == r_sel);
    assign w_other_hit = w_single && (w_err != r_sel);

    assign w_leak    = (r_win == WIN_W'(WINDOW - 1));
    assign w_tmo_hit = (r_tmo == TMO_W'(RESYNC_TIMEOUT));

    // Threshold is judged on the saturated count this fault produces.
    always_comb begin
        w_hit_cnt = '0;
        for (int i = 0; i < REPL_NUM; i++) begin
            if (w_err[i]) begin
                w_hit_cnt = w_hit_cnt | w_cnt[i];
            end
        end
    end
    assign w_post_cnt   = (w_hit_cnt == '1) ? w_hit_cnt : w_hit_cnt + 1'b1;
    assign w_thresh_hit = (w_post_cnt >= CNT_W'(THRESH));

    genvar gi;
    generate
        for (gi = 0; gi < REPL_NUM; gi++) begin : g_cnt
            cv32e40p_tmr_err_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk      (clk),
                .rst_n    (rst_n),
                .inc_i    (w_single && w_err[gi]),
                .leak_i   (w_leak),
                .freeze_i (r_disable[gi]),
                .cnt_o    (w_cnt[gi])
            );
            assign err_cnt_o[gi*CNT_W +: CNT_W] = w_cnt[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_req     <= 1'b0;
            r_sel     <= 3'b000;
            r_disable <= 3'b000;
            r_fatal   <= 1'b0;
            r_tmo     <= '0;
            r_win     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_req     <= w_req_nxt;
            r_sel     <= w_sel_nxt;
            r_disable <= w_disable_nxt;
            r_fatal   <= w_fatal_nxt;
            r_tmo     <= w_tmo_nxt;
            r_win     <= w_leak ? '0 : r_win + 1'b1;
        end
    end

    // In RESYNC a foreign or multi fault outranks ack, and ack outranks timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (w_multi) begin
                    w_state_nxt = FATAL;
                end else if (w_single) begin
                    w_state_nxt = w_thresh_hit ? DEGRADED : RESYNC;
                end
            end
            RESYNC: begin
                if (w_multi || w_other_hit) begin
                    w_state_nxt = FATAL;
                end else if (resync_ack_i) begin
                    w_state_nxt = RUN;
                end else if (w_tmo_hit) begin
                    w_state_nxt = DEGRADED;
                end
            end
            DEGRADED: begin
                if (w_nerr != 2'd0) begin
                    w_state_nxt = FATAL;
                end
            end
            FATAL:   w_state_nxt = FATAL;
            default: w_state_nxt = FATAL;
        endcase
    end

    // r_tmo counts request-high cycles: 1 on the first cycle req is visible.
    always_comb begin
        w_req_nxt     = (w_state_nxt == RESYNC);
        w_fatal_nxt   = (w_state_nxt == FATAL);
        w_sel_nxt     = r_sel;
        w_disable_nxt = r_disable;
        w_tmo_nxt     = '0;
        if ((r_state == RUN) && (w_state_nxt == RESYNC)) begin
            w_sel_nxt = w_err;
        end
        if ((r_state == RUN) && (w_state_nxt == DEGRADED)) begin
            w_disable_nxt = r_disable | w_err;
        end
        if ((r_state == RESYNC) && (w_state_nxt == DEGRADED)) begin
            w_disable_nxt = r_disable | r_sel;
        end
        if (w_state_nxt == RESYNC) begin
            w_tmo_nxt = (r_state == RESYNC) ? r_tmo + 1'b1 : TMO_W'(1);
        end
    end

    assign resync_req_o      = r_req;
    assign resync_sel_o      = r_sel;
    assign replica_disable_o = r_disable;
    assign fatal_o           = r_fatal;
    assign state_o           = r_state;

    // w_sel_hit documents the "own replica" case that keeps RESYNC alive.
    logic w_unused;
    assign w_unused = w_sel_hit;

endmodule

// File: tb/tb_cv32e40p_tmr_fault_manager.sv
module tb_cv32e40p_tmr_fault_manager;

    localparam int CNT_W  = 8;
    localparam int THRESH = 4;
    localparam int WINDOW = 1024;
    localparam int TMO    = 64;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic valid = 1'b0, ea = 1'b0, eb = 1'b0, ec = 1'b0, ack = 1'b0;
    logic               req_o;
    logic [2:0]         sel_o;
    logic [2:0]         dis_o;
    logic               fatal_o;
    logic [1:0]         state_o;
    logic [3*CNT_W-1:0] cnt_o;

    cv32e40p_tmr_fault_manager #(
        .CNT_W(CNT_W), .THRESH(THRESH), .WINDOW(WINDOW), .RESYNC_TIMEOUT(TMO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .valid_i           (valid),
        .err_a_i           (ea),
        .err_b_i           (eb),
        .err_c_i           (ec),
        .resync_ack_i      (ack),
        .resync_req_o      (req_o),
        .resync_sel_o      (sel_o),
        .replica_disable_o (dis_o),
        .fatal_o           (fatal_o),
        .state_o           (state_o),
        .err_cnt_o         (cnt_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode 0 run, 1 resync pending, 2 one replica isolated, 3 fatal.
    int       m_cnt [3];
    bit [2:0] m_dis;
    bit [2:0] m_sel;
    int       m_mode;
    int       m_tmo;
    int       m_edge;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        m_dis  = 3'b000;
        m_sel  = 3'b000;
        m_mode = 0;
        m_tmo  = 0;
        m_edge = 0;
    endtask

    task automatic model_step(input bit v, input bit a, input bit b, input bit c, input bit k);
        bit [2:0] eff;
        bit [2:0] dis_prev;
        int n, idx, post;
        bit leak, inc;
        eff = v ? ({c, b, a} & ~m_dis) : 3'b000;
        n = 0; idx = 0;
        for (int i = 0; i < 3; i++) if (eff[i]) begin n++; idx = i; end
        leak = ((m_edge % WINDOW) == WINDOW - 1);
        post = (n == 1) ? ((m_cnt[idx] + 1 > CMAX) ? CMAX : m_cnt[idx] + 1) : 0;
        dis_prev = m_dis;
        case (m_mode)
            0: if (n >= 2) m_mode = 3;
               else if (n == 1) begin
                   if (post >= THRESH) begin m_dis[idx] = 1'b1; m_mode = 2; end
                   else begin m_mode = 1; m_sel = eff; m_tmo = 1; end
               end
            1: if (n >= 2 || (n == 1 && eff != m_sel)) m_mode = 3;
               else if (k) m_mode = 0;
               else if (m_tmo == TMO) begin m_dis = m_dis | m_sel; m_mode = 2; end
               else m_tmo++;
            2: if (n >= 1) m_mode = 3;
            default: ;
        endcase
        for (int i = 0; i < 3; i++) begin
            if (!dis_prev[i]) begin
                inc = (n == 1) && (idx == i);
                if (inc && !leak) m_cnt[i] = (m_cnt[i] >= CMAX) ? CMAX : m_cnt[i] + 1;
                else if (!inc && leak && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
            end
        end
        m_edge++;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".req"},   32'(req_o),   32'(m_mode == 1));
        check({tag, ".sel"},   32'(sel_o),   32'(m_sel));
        check({tag, ".dis"},   32'(dis_o),   32'(m_dis));
        check({tag, ".fatal"}, 32'(fatal_o), 32'(m_mode == 3));
        check({tag, ".state"}, 32'(state_o), 32'(m_mode));
        check({tag, ".cnt_a"}, 32'(cnt_o[7:0]),   32'(m_cnt[0]));
        check({tag, ".cnt_b"}, 32'(cnt_o[15:8]),  32'(m_cnt[1]));
        check({tag, ".cnt_c"}, 32'(cnt_o[23:16]), 32'(m_cnt[2]));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs sampled 1 after the next.
    task automatic step(input bit v, input bit a, input bit b, input bit c, input bit k);
        valid = v; ea = a; eb = b; ec = c; ack = k;
        @(posedge clk);
        model_step(v, a, b, c, k);
        #1;
        check_all("step");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input string tag);
        valid = 0; ea = 0; eb = 0; ec = 0; ack = 0;
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int req_cycles;
        bit v, a, b, c, k;

        // reset
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        check("reset.req", 32'(req_o), 32'd0);
        check("reset.state", 32'(state_o), 32'd0);
        #10 rst_n = 1'b1;

        // 1: single fault on B, acked after 3 cycles
        step(1, 0, 1, 0, 0);
        check("t1.req", 32'(req_o), 32'd1);
        check("t1.sel", 32'(sel_o), 32'b010);
        idle(2);
        step(0, 0, 0, 0, 1);
        check("t1.req_after_ack", 32'(req_o), 32'd0);
        check("t1.state", 32'(state_o), 32'd0);
        check("t1.cnt_b", 32'(cnt_o[15:8]), 32'd1);

        // 2: four A faults, 4th hits the threshold, then C fault is fatal
        do_reset("t2.reset");
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0, 0);
            if (i < 3) step(0, 0, 0, 0, 1);
        end
        check("t2.dis", 32'(dis_o), 32'b001);
        check("t2.state", 32'(state_o), 32'd2);
        check("t2.req", 32'(req_o), 32'd0);
        check("t2.cnt_a", 32'(cnt_o[7:0]), 32'd4);
        step(1, 1, 0, 0, 0);
        check("t2.a_ignored", 32'(state_o), 32'd2);
        step(1, 0, 0, 1, 0);
        check("t2.fatal", 32'(fatal_o), 32'd1);

        // 3: C fault, never acked
        do_reset("t3.reset");
        step(1, 0, 0, 1, 0);
        req_cycles = 0;
        guard = 0;
        while (req_o && guard < 200) begin
            req_cycles++;
            guard++;
            step(0, 0, 0, 0, 0);
        end
        check("t3.req_cycles", 32'(req_cycles), 32'd64);
        check("t3.req", 32'(req_o), 32'd0);
        check("t3.dis", 32'(dis_o), 32'b100);
        check("t3.state", 32'(state_o), 32'd2);

        // 4: triple fault; invalid cycle first must be ignored
        do_reset("t4.reset");
        step(0, 1, 1, 1, 0);
        check("t4.invalid_state", 32'(state_o), 32'd0);
        check("t4.invalid_fatal", 32'(fatal_o), 32'd0);
        step(1, 1, 1, 1, 0);
        check("t4.fatal", 32'(fatal_o), 32'd1);
        check("t4.state", 32'(state_o), 32'd3);
        step(1, 1, 0, 0, 0);
        check("t4.fatal_sticky", 32'(fatal_o), 32'd1);
        check("t4.cnt_a_counts", 32'(cnt_o[7:0]), 32'd1);

        // 5: leak to zero over two windows; fault on the wrap cycle
        do_reset("t5.reset");
        step(1, 1, 0, 0, 0); step(0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0); step(0, 0, 0, 0, 1);
        check("t5.cnt_a_2", 32'(cnt_o[7:0]), 32'd2);
        idle(2 * WINDOW);
        check("t5.cnt_a_0", 32'(cnt_o[7:0]), 32'd0);
        step(1, 1, 0, 0, 0); step(0, 0, 0, 0, 1);
        guard = 0;
        while (((m_edge % WINDOW) != WINDOW - 1) && guard < WINDOW + 4) begin
            guard++;
            step(0, 0, 0, 0, 0);
        end
        check("t5.pre_wrap", 32'(cnt_o[7:0]), 32'd1);
        step(1, 1, 0, 0, 0);
        check("t5.wrap_unchanged", 32'(cnt_o[7:0]), 32'd1);
        step(0, 0, 0, 0, 1);

        // 6: reset mid-RESYNC
        do_reset("t6.pre");
        step(1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        check("t6.in_resync", 32'(req_o), 32'd1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("t6.req", 32'(req_o), 32'd0);
        check("t6.dis", 32'(dis_o), 32'd0);
        check("t6.fatal", 32'(fatal_o), 32'd0);
        check("t6.cnt", 32'(cnt_o), 32'd0);
        check("t6.state", 32'(state_o), 32'd0);
        #1 rst_n = 1'b1;

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset("rnd.reset");
            v = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 19) == 0);
            b = ($urandom_range(0, 19) == 0);
            c = ($urandom_range(0, 19) == 0);
            k = (m_mode == 1) && ($urandom_range(0, 3) == 0);
            step(v, a, b, c, k);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
